// File: rtl/cache_port_arbiter.sv
// ---------------------------------------------------------------------------
// cache_port_arbiter
//
// Shares the single CPU-side port of the cache between two requesters (m0,
// m1). Requesters hold a level request; the arbiter picks one round-robin,
// turns the request into a one-cycle read or write strobe towards the cache,
// waits for cpu_ready and hands the read data / hit flag back with a
// one-cycle done pulse. A watchdog aborts a transaction if the cache never
// answers, reporting it through a done+err pulse with zeroed data.
//
// Ports:
//   clk, rst                   clock (rising edge), async active-high reset
//   i_mN_valid                 request pending, held until o_mN_done
//   i_mN_write                 1 = write, 0 = read
//   i_mN_addr / i_mN_wdata     request address / write data
//   o_mN_done                  one-cycle completion pulse
//   o_mN_rdata / o_mN_hit      cache read data / hit, valid with done
//   o_mN_err                   one-cycle timeout flag, coincident with done
//   o_cpu_addr / o_cpu_wdata   address / write data towards the cache
//   o_cpu_read / o_cpu_write   one-cycle access strobes
//   i_cpu_rdata / i_cpu_hit    cache response, valid with i_cpu_ready
//   i_cpu_ready                cache completion pulse
//   o_busy                     high whenever a transaction is in progress
//   o_grant_id                 requester currently owning the port
// ---------------------------------------------------------------------------
module cache_port_arbiter #(
   parameter int ADDR_WIDTH     = 16,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                  clk,
   input  logic                  rst,

   input  logic                  i_m0_valid,
   input  logic                  i_m0_write,
   input  logic [ADDR_WIDTH-1:0] i_m0_addr,
   input  logic [DATA_WIDTH-1:0] i_m0_wdata,
   output logic                  o_m0_done,
   output logic [DATA_WIDTH-1:0] o_m0_rdata,
   output logic                  o_m0_hit,
   output logic                  o_m0_err,

   input  logic                  i_m1_valid,
   input  logic                  i_m1_write,
   input  logic [ADDR_WIDTH-1:0] i_m1_addr,
   input  logic [DATA_WIDTH-1:0] i_m1_wdata,
   output logic                  o_m1_done,
   output logic [DATA_WIDTH-1:0] o_m1_rdata,
   output logic                  o_m1_hit,
   output logic                  o_m1_err,

   output logic [ADDR_WIDTH-1:0] o_cpu_addr,
   output logic [DATA_WIDTH-1:0] o_cpu_wdata,
   output logic                  o_cpu_read,
   output logic                  o_cpu_write,
   input  logic [DATA_WIDTH-1:0] i_cpu_rdata,
   input  logic                  i_cpu_ready,
   input  logic                  i_cpu_hit,

   output logic                  o_busy,
   output logic                  o_grant_id
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      ARB   = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_nextState;

   logic                  r_lastGrant;
   logic                  r_grantId;
   logic [CNT_W-1:0]      r_count;

   logic [ADDR_WIDTH-1:0] r_cpuAddr;
   logic [DATA_WIDTH-1:0] r_cpuWdata;
   logic                  r_cpuRead;
   logic                  r_cpuWrite;

   logic                  r_m0Done;
   logic [DATA_WIDTH-1:0] r_m0Rdata;
   logic                  r_m0Hit;
   logic                  r_m0Err;
   logic                  r_m1Done;
   logic [DATA_WIDTH-1:0] r_m1Rdata;
   logic                  r_m1Hit;
   logic                  r_m1Err;

   logic                  w_elig0;
   logic                  w_elig1;
   logic                  w_anyElig;
   logic                  w_winner;
   logic                  w_selWrite;
   logic [ADDR_WIDTH-1:0] w_selAddr;
   logic [DATA_WIDTH-1:0] w_selWdata;
   logic                  w_expire;

   // A requester whose done pulse is showing this cycle has not yet had the
   // chance to drop valid, so it is hidden from arbitration for that cycle.
   // On a tie the requester that was not served last wins.
   assign w_elig0    = i_m0_valid & ~r_m0Done;
   assign w_elig1    = i_m1_valid & ~r_m1Done;
   assign w_anyElig  = w_elig0 | w_elig1;
   assign w_winner   = (w_elig0 & w_elig1) ? ~r_lastGrant : w_elig1;
   assign w_selWrite = w_winner ? i_m1_write : i_m0_write;
   assign w_selAddr  = w_winner ? i_m1_addr  : i_m0_addr;
   assign w_selWdata = w_winner ? i_m1_wdata : i_m0_wdata;

   // The counter holds the number of WAIT cycles already spent, so the abort
   // fires on the TIMEOUT_CYCLES-th WAIT cycle without cpu_ready.
   assign w_expire   = (r_count == CNT_LAST);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ARB;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic: ISSUE always lasts one cycle; WAIT leaves on either a
   // cache response or the watchdog expiring.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         ARB: begin
            if (w_anyElig) begin
               w_nextState = ISSUE;
            end
         end
         ISSUE: begin
            w_nextState = WAIT;
         end
         WAIT: begin
            if (i_cpu_ready || w_expire) begin
               w_nextState = ARB;
            end
         end
         default: begin
            w_nextState = ARB;
         end
      endcase
   end

   // Registered datapath. The cache strobes are loaded on the grant edge so
   // they are visible exactly during ISSUE; address/data stay on the port for
   // the whole transaction. Done/err are pulses and default low every cycle,
   // while rdata/hit keep their last value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_lastGrant <= 1'b1;
         r_grantId   <= 1'b0;
         r_count     <= '0;
         r_cpuAddr   <= '0;
         r_cpuWdata  <= '0;
         r_cpuRead   <= 1'b0;
         r_cpuWrite  <= 1'b0;
         r_m0Done    <= 1'b0;
         r_m0Rdata   <= '0;
         r_m0Hit     <= 1'b0;
         r_m0Err     <= 1'b0;
         r_m1Done    <= 1'b0;
         r_m1Rdata   <= '0;
         r_m1Hit     <= 1'b0;
         r_m1Err     <= 1'b0;
      end else begin
         r_cpuRead  <= 1'b0;
         r_cpuWrite <= 1'b0;
         r_m0Done   <= 1'b0;
         r_m0Err    <= 1'b0;
         r_m1Done   <= 1'b0;
         r_m1Err    <= 1'b0;
         case (r_state)
            ARB: begin
               if (w_anyElig) begin
                  r_grantId  <= w_winner;
                  r_cpuAddr  <= w_selAddr;
                  r_cpuWdata <= w_selWdata;
                  r_cpuRead  <= ~w_selWrite;
                  r_cpuWrite <= w_selWrite;
               end
            end
            ISSUE: begin
               r_count <= '0;
            end
            WAIT: begin
               if (i_cpu_ready) begin
                  r_lastGrant <= r_grantId;
                  if (r_grantId) begin
                     r_m1Done  <= 1'b1;
                     r_m1Rdata <= i_cpu_rdata;
                     r_m1Hit   <= i_cpu_hit;
                  end else begin
                     r_m0Done  <= 1'b1;
                     r_m0Rdata <= i_cpu_rdata;
                     r_m0Hit   <= i_cpu_hit;
                  end
               end else if (w_expire) begin
                  r_lastGrant <= r_grantId;
                  if (r_grantId) begin
                     r_m1Done  <= 1'b1;
                     r_m1Err   <= 1'b1;
                     r_m1Rdata <= '0;
                     r_m1Hit   <= 1'b0;
                  end else begin
                     r_m0Done  <= 1'b1;
                     r_m0Err   <= 1'b1;
                     r_m0Rdata <= '0;
                     r_m0Hit   <= 1'b0;
                  end
               end else begin
                  r_count <= r_count + CNT_W'(1);
               end
            end
            default: begin
               r_count <= '0;
            end
         endcase
      end
   end

   assign o_cpu_addr  = r_cpuAddr;
   assign o_cpu_wdata = r_cpuWdata;
   assign o_cpu_read  = r_cpuRead;
   assign o_cpu_write = r_cpuWrite;
   assign o_m0_done   = r_m0Done;
   assign o_m0_rdata  = r_m0Rdata;
   assign o_m0_hit    = r_m0Hit;
   assign o_m0_err    = r_m0Err;
   assign o_m1_done   = r_m1Done;
   assign o_m1_rdata  = r_m1Rdata;
   assign o_m1_hit    = r_m1Hit;
   assign o_m1_err    = r_m1Err;
   assign o_grant_id  = r_grantId;
   assign o_busy      = (r_state != ARB);

endmodule

// File: tb/tb_cache_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cache_port_arbiter
//
// Bench for cache_port_arbiter (TIMEOUT_CYCLES = 8). Two requester agents
// replay queued requests, a cache responder answers each strobe after a
// queued delay (0 = never answer), and a transaction-level model predicts
// every output on every cycle. Directed phases add literal expectations for
// latency, grant order, timeout and reset behaviour.
// ---------------------------------------------------------------------------
module tb_cache_port_arbiter;

   localparam int TO = 8;

   typedef struct {
      logic        wr;
      logic [15:0] addr;
      logic [31:0] wdata;
   } req_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  mValid = '0;
   logic [1:0]  mWrite = '0;
   logic [15:0] mAddr [2];
   logic [31:0] mWdata [2];
   logic [31:0] respData = '0;
   logic        respHit = 1'b0;
   logic        cpuReady = 1'b0;

   logic        o_m0_done, o_m0_hit, o_m0_err;
   logic        o_m1_done, o_m1_hit, o_m1_err;
   logic [31:0] o_m0_rdata, o_m1_rdata, o_cpu_wdata;
   logic [15:0] o_cpu_addr;
   logic        o_cpu_read, o_cpu_write, o_busy, o_grant_id;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   req_t q0[$];
   req_t q1[$];
   int   delQ[$];

   // Transaction-level model state.
   logic        expRead, expWrite, expBusy, expGrant;
   logic [15:0] expAddr;
   logic [31:0] expWdata;
   logic [1:0]  expDone, expErr, expHit;
   logic [31:0] expRdata [2];
   bit          active;
   int          owner, lastOwner, grantCycle;

   // Event log filled from observed outputs, inspected by directed checks.
   int   rdStrobes, wrStrobes, firstStrobeCycle;
   int   doneCnt [2];
   int   errCnt [2];
   int   doneCycle [2];
   int   firstRaise [2];
   logic [31:0] lastRdata [2];
   logic [1:0]  lastHit;
   logic [31:0] strobeWdata;
   int   grantLog[$];

   cache_port_arbiter #(
      .ADDR_WIDTH(16), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rst(rst),
      .i_m0_valid(mValid[0]), .i_m0_write(mWrite[0]),
      .i_m0_addr(mAddr[0]), .i_m0_wdata(mWdata[0]),
      .o_m0_done(o_m0_done), .o_m0_rdata(o_m0_rdata),
      .o_m0_hit(o_m0_hit), .o_m0_err(o_m0_err),
      .i_m1_valid(mValid[1]), .i_m1_write(mWrite[1]),
      .i_m1_addr(mAddr[1]), .i_m1_wdata(mWdata[1]),
      .o_m1_done(o_m1_done), .o_m1_rdata(o_m1_rdata),
      .o_m1_hit(o_m1_hit), .o_m1_err(o_m1_err),
      .o_cpu_addr(o_cpu_addr), .o_cpu_wdata(o_cpu_wdata),
      .o_cpu_read(o_cpu_read), .o_cpu_write(o_cpu_write),
      .i_cpu_rdata(respData), .i_cpu_ready(cpuReady), .i_cpu_hit(respHit),
      .o_busy(o_busy), .o_grant_id(o_grant_id)
   );

   // Clock and cycle counter.
   initial forever #5 clk = ~clk;
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Hard stop in case something wedges the whole bench.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input int id, input logic wr, input logic [15:0] addr, input logic [31:0] wdata);
      req_t r;
      r.wr = wr;
      r.addr = addr;
      r.wdata = wdata;
      if (id == 0) q0.push_back(r);
      else         q1.push_back(r);
   endtask

   task automatic clearLog();
      rdStrobes = 0;
      wrStrobes = 0;
      firstStrobeCycle = -1;
      doneCnt = '{0, 0};
      errCnt = '{0, 0};
      doneCycle = '{0, 0};
      firstRaise = '{-1, -1};
      lastRdata = '{32'hFFFF_FFFF, 32'hFFFF_FFFF};
      lastHit = 2'b11;
      strobeWdata = '0;
      grantLog.delete();
   endtask

   task automatic waitIdle(input string name);
      int  n = 0;
      bit  idle = 0;
      while (!idle && n < 300) begin
         @(posedge clk);
         #3;
         n++;
         if (q0.size() == 0 && q1.size() == 0 && mValid == 2'b00 && !o_busy) idle = 1;
      end
      checks++;
      if (!idle) begin
         errors++;
         $display("[TB] FAIL %s idle: got busy after %0d cycles required idle", name, n);
      end
      repeat (2) @(posedge clk);
   endtask

   // Requester agents: hold valid until done, then move to the next queued
   // request in the same cycle (keeping valid high if more are queued).
   initial forever begin
      @(posedge clk);
      #2;
      if (rst) begin
         q0.delete();
         q1.delete();
         mValid = 2'b00;
      end else begin
         if (mValid[0] && o_m0_done) begin
            void'(q0.pop_front());
            mValid[0] = 1'b0;
         end
         if (!mValid[0] && q0.size() > 0) begin
            mValid[0] = 1'b1;
            mWrite[0] = q0[0].wr;
            mAddr[0]  = q0[0].addr;
            mWdata[0] = q0[0].wdata;
            if (firstRaise[0] < 0) firstRaise[0] = cyc;
         end
         if (mValid[1] && o_m1_done) begin
            void'(q1.pop_front());
            mValid[1] = 1'b0;
         end
         if (!mValid[1] && q1.size() > 0) begin
            mValid[1] = 1'b1;
            mWrite[1] = q1[0].wr;
            mAddr[1]  = q1[0].addr;
            mWdata[1] = q1[0].wdata;
            if (firstRaise[1] < 0) firstRaise[1] = cyc;
         end
      end
   end

   // Cache responder: each strobe takes the next delay from delQ (default 1);
   // ready is raised that many cycles after the strobe cycle, 0 means never.
   initial begin
      int cd = 0;
      forever begin
         @(posedge clk);
         #2;
         cpuReady = 1'b0;
         if (rst) begin
            cd = 0;
            delQ.delete();
         end else begin
            if (cd > 0) begin
               cd--;
               if (cd == 0) cpuReady = 1'b1;
            end
            if (o_cpu_read || o_cpu_write) begin
               cd = (delQ.size() > 0) ? delQ.pop_front() : 1;
            end
         end
      end
   end

   task automatic modelReset();
      expRead = 0; expWrite = 0; expBusy = 0; expGrant = 0;
      expAddr = '0; expWdata = '0;
      expDone = '0; expErr = '0; expHit = '0;
      expRdata = '{32'h0, 32'h0};
      active = 0; owner = 0; lastOwner = 1; grantCycle = 0;
   endtask

   task automatic modelFinish(input logic [31:0] data, input logic hit, input logic err);
      expDone[owner] = 1'b1;
      expErr[owner]  = err;
      expRdata[owner] = data;
      expHit[owner]  = hit;
      lastOwner = owner;
      active = 0;
   endtask

   // Predict outputs for the next cycle from this cycle's inputs: a grant
   // produces a strobe next cycle, the waiting phase starts two cycles after
   // the grant, and done follows ready or the TO-th silent waiting cycle.
   task automatic modelStep();
      logic [1:0] elig;
      int w;
      elig[0] = mValid[0] && !expDone[0];
      elig[1] = mValid[1] && !expDone[1];
      expDone = '0; expErr = '0; expRead = 0; expWrite = 0;
      if (!active) begin
         if (elig != 2'b00) begin
            if (elig == 2'b11) w = (lastOwner == 0) ? 1 : 0;
            else               w = elig[1] ? 1 : 0;
            active = 1;
            owner = w;
            grantCycle = cyc;
            expGrant = (w == 1);
            expRead  = !mWrite[w];
            expWrite = mWrite[w];
            expAddr  = mAddr[w];
            expWdata = mWdata[w];
         end
      end else if (cyc >= grantCycle + 2) begin
         if (cpuReady) modelFinish(respData, respHit, 1'b0);
         else if (cyc - (grantCycle + 2) + 1 == TO) modelFinish(32'h0, 1'b0, 1'b1);
      end
      expBusy = active;
   endtask

   // Compare process plus event logger, at the falling edge.
   initial forever begin
      @(negedge clk);
      if (rst) modelReset();
      checkOutput($sformatf("cpu port @%0d", cyc),
                  {o_cpu_read, o_cpu_write, o_cpu_addr, o_cpu_wdata},
                  {expRead, expWrite, expAddr, expWdata});
      checkOutput($sformatf("requester outputs @%0d", cyc),
                  {o_m0_done, o_m0_err, o_m0_hit, o_m0_rdata, o_m1_done, o_m1_err, o_m1_hit, o_m1_rdata},
                  {expDone[0], expErr[0], expHit[0], expRdata[0], expDone[1], expErr[1], expHit[1], expRdata[1]});
      checkOutput($sformatf("busy/grant @%0d", cyc), {o_busy, o_grant_id}, {expBusy, expGrant});
      if (!rst) modelStep();

      if (o_cpu_read || o_cpu_write) begin
         if (firstStrobeCycle < 0) firstStrobeCycle = cyc;
         if (o_cpu_read)  rdStrobes++;
         if (o_cpu_write) wrStrobes++;
         strobeWdata = o_cpu_wdata;
         grantLog.push_back(o_grant_id ? 1 : 0);
      end
      if (o_m0_done) begin
         doneCnt[0]++; doneCycle[0] = cyc; lastRdata[0] = o_m0_rdata; lastHit[0] = o_m0_hit;
         if (o_m0_err) errCnt[0]++;
      end
      if (o_m1_done) begin
         doneCnt[1]++; doneCycle[1] = cyc; lastRdata[1] = o_m1_rdata; lastHit[1] = o_m1_hit;
         if (o_m1_err) errCnt[1]++;
      end
   end

   initial begin
      int n;
      mAddr = '{16'h0, 16'h0};
      mWdata = '{32'h0, 32'h0};
      clearLog();
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset busy/grant", {o_busy, o_grant_id}, 2'b00);
      checkOutput("reset strobes/done", {o_cpu_read, o_cpu_write, o_m0_done, o_m1_done}, 4'b0);
      rst = 1'b0;

      // Single read from m0, ready two cycles after the strobe.
      clearLog();
      respData = 32'hDEAD_BEEF; respHit = 1'b0;
      delQ.push_back(2);
      applyStimulus(0, 1'b0, 16'h0000, 32'h0);
      waitIdle("single read");
      checkOutput("read strobes", {rdStrobes[7:0], wrStrobes[7:0]}, {8'd1, 8'd0});
      checkOutput("read m0 done count", doneCnt[0], 1);
      checkOutput("read m0 rdata/hit", {lastRdata[0], lastHit[0]}, {32'hDEAD_BEEF, 1'b0});
      checkOutput("read latency", doneCycle[0] - firstRaise[0], 4);
      checkOutput("read m1 untouched", {o_m1_rdata, o_m1_hit, doneCnt[1][7:0]}, 41'h0);

      // Write from m1 at minimum latency.
      clearLog();
      respData = 32'h5555_AAAA; respHit = 1'b1;
      applyStimulus(1, 1'b1, 16'h0008, 32'h1111_1111);
      waitIdle("write");
      checkOutput("write strobes", {rdStrobes[7:0], wrStrobes[7:0]}, {8'd0, 8'd1});
      checkOutput("write wdata", strobeWdata, 32'h1111_1111);
      checkOutput("write m1 rdata/hit", {lastRdata[1], lastHit[1]}, {32'h5555_AAAA, 1'b1});
      checkOutput("write min latency", doneCycle[1] - firstRaise[1], 3);

      // Contention: both raise together, each re-requests once.
      clearLog();
      respData = 32'h0BAD_F00D; respHit = 1'b0;
      applyStimulus(0, 1'b0, 16'h0000, 32'h0);
      applyStimulus(1, 1'b0, 16'h0400, 32'h0);
      applyStimulus(0, 1'b0, 16'h0000, 32'h0);
      applyStimulus(1, 1'b0, 16'h0400, 32'h0);
      waitIdle("contention");
      n = grantLog.size();
      checkOutput("contention grant count", n, 4);
      if (n == 4)
         checkOutput("contention grant order",
                     {grantLog[0][0], grantLog[1][0], grantLog[2][0], grantLog[3][0]}, 4'b0101);

      // m0 keeps valid high across three requests: one strobe per done.
      clearLog();
      applyStimulus(0, 1'b0, 16'h0100, 32'h0);
      applyStimulus(0, 1'b0, 16'h0104, 32'h0);
      applyStimulus(0, 1'b0, 16'h0108, 32'h0);
      waitIdle("mask");
      checkOutput("mask strobes/dones", {rdStrobes[7:0], doneCnt[0][7:0]}, {8'd3, 8'd3});
      checkOutput("mask span", doneCycle[0] - firstRaise[0], 11);

      // Timeout on m0 (cache silent), then m1 is served.
      clearLog();
      respData = 32'h1234_5678; respHit = 1'b1;
      delQ.push_back(0);
      delQ.push_back(2);
      applyStimulus(0, 1'b0, 16'h0010, 32'h0);
      @(posedge clk);
      #1;
      applyStimulus(1, 1'b0, 16'h0020, 32'h0);
      waitIdle("timeout");
      checkOutput("timeout err counts", {errCnt[0][7:0], errCnt[1][7:0]}, {8'd1, 8'd0});
      checkOutput("timeout m0 rdata/hit", {lastRdata[0], lastHit[0]}, 33'h0);
      checkOutput("timeout duration", doneCycle[0] - firstStrobeCycle, 9);
      n = grantLog.size();
      checkOutput("timeout grant count", n, 2);
      if (n == 2) checkOutput("timeout grant order", {grantLog[0][0], grantLog[1][0]}, 2'b01);
      checkOutput("timeout m1 rdata", lastRdata[1], 32'h1234_5678);

      // Reset in the middle of an m1 WAIT; m0 served just before.
      clearLog();
      applyStimulus(0, 1'b0, 16'h0030, 32'h0);
      waitIdle("pre-reset");
      clearLog();
      delQ.push_back(0);
      applyStimulus(1, 1'b0, 16'h0034, 32'h0);
      n = 0;
      while (rdStrobes == 0 && n < 50) begin
         @(posedge clk);
         n++;
      end
      checkOutput("reset phase strobe seen", rdStrobes, 1);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      checkOutput("async reset outputs",
                  {o_cpu_read, o_cpu_write, o_cpu_addr, o_cpu_wdata, o_busy, o_grant_id,
                   o_m0_done, o_m0_err, o_m0_hit, o_m0_rdata, o_m1_done, o_m1_err, o_m1_hit, o_m1_rdata},
                  128'h0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      checkOutput("no done across reset", {doneCnt[1][7:0], errCnt[1][7:0]}, 16'h0);
      clearLog();
      applyStimulus(0, 1'b0, 16'h0040, 32'h0);
      applyStimulus(1, 1'b0, 16'h0050, 32'h0);
      waitIdle("post-reset");
      n = grantLog.size();
      checkOutput("post-reset grant count", n, 2);
      if (n == 2) checkOutput("post-reset grant order", {grantLog[0][0], grantLog[1][0]}, 2'b01);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
